// File: rtl/i2c_slave.sv
// i2c_slave: single-address I2C target with oversampled sclk/sda, ACK generation, rx/tx byte handling.
// Define I2C_SLAVE_GENCALL_EN to also accept general-call (7'h00) writes.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_match,
    output logic       busy,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ADDR     = 4'd1,
        ADDR_ACK = 4'd2,
        RX       = 4'd3,
        RX_ACK   = 4'd4,
        TX       = 4'd5,
        TX_ACK   = 4'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [7:0]             shift_q, shift_d, tx_q, tx_d, rx_data_q, rx_data_d;
    logic                   rw_q, rw_d, oe_q, oe_d, busy_q, busy_d, match_q, match_d;
    logic                   rx_valid_q, rx_valid_d, tx_req_q, tx_req_d, ack_q, ack_d;
    logic                   scl_s, sda_s, rise, fall, start, stop, hit;
    logic [7:0]             byte_in;

    assign sda        = oe_q ? 1'b0 : 1'bz;
    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign rise       = scl_s & ~scl_prev_q;
    assign fall       = ~scl_s & scl_prev_q;
    assign start      = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop       = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign tx_req     = tx_req_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign addr_match = match_q;
    assign busy       = busy_q;
    assign state      = state_q;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], sclk};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        rw_d       = rw_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        match_d    = match_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        ack_d      = ack_q;
        byte_in    = {shift_q[6:0], sda_s};
`ifdef I2C_SLAVE_GENCALL_EN
        hit = (byte_in[7:1] == SLAVE_ADDR) || (byte_in[7:1] == 7'h00 && !byte_in[0]);
`else
        hit = byte_in[7:1] == SLAVE_ADDR;
`endif
        if (stop) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            match_d = 1'b0;
            ack_d   = 1'b0;
        end else if (start) begin
            state_d = ADDR;
            cnt_d   = 3'd0;
            oe_d    = 1'b0;
            busy_d  = 1'b1;
            match_d = 1'b0;
            ack_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (rise) begin
                    shift_d = byte_in;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d  = hit ? ADDR_ACK : IDLE;
                        match_d  = hit;
                        rw_d     = byte_in[0];
                        tx_req_d = hit & byte_in[0];
                    end
                end
                // ACK slots: first fall drives low, second fall releases and moves on
                ADDR_ACK: if (fall) begin
                    oe_d = 1'b1;
                    if (oe_q) begin
                        cnt_d   = 3'd0;
                        tx_d    = tx_data;
                        oe_d    = rw_q & ~tx_data[7];
                        state_d = rw_q ? TX : RX;
                    end
                end
                RX: if (rise) begin
                    shift_d = byte_in;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        rx_data_d  = byte_in;
                        rx_valid_d = 1'b1;
                        state_d    = RX_ACK;
                    end
                end
                RX_ACK: if (fall) begin
                    oe_d    = ~oe_q;
                    state_d = oe_q ? RX : RX_ACK;
                end
                TX: if (fall) begin
                    cnt_d   = cnt_q + 3'd1;
                    tx_d    = {tx_q[6:0], 1'b0};
                    oe_d    = (cnt_q != 3'd7) & ~tx_q[6];
                    state_d = (cnt_q == 3'd7) ? TX_ACK : TX;
                end
                TX_ACK: begin
                    if (rise) begin
                        ack_d    = ~sda_s;
                        tx_req_d = ~sda_s;
                        match_d  = ~sda_s;
                        state_d  = sda_s ? IDLE : TX_ACK;
                    end else if (fall && ack_q) begin
                        ack_d   = 1'b0;
                        cnt_d   = 3'd0;
                        tx_d    = tx_data;
                        oe_d    = ~tx_data[7];
                        state_d = TX;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 8'd0;
            rw_q       <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            match_q    <= 1'b0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            rw_q       <= rw_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            match_q    <= match_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            ack_q      <= ack_d;
        end
    end
endmodule
